// File: rtl/sync_fifo_flex_pkg.sv
// Shared constants and helpers for the flexible synchronous FIFO.
// The pointer wrap helper lets depths that are not a power of two share the same pointer logic.
package sync_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Explicit wrap: pointers never rely on binary rollover.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_flex_mem.sv
// Storage array for the FIFO: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int F_WIDTH = 8,
    parameter int F_DEPTH = 4,
    parameter int A_WIDTH = 2
) (
    input  logic               clk,
    input  logic               we,
    input  logic [A_WIDTH-1:0] waddr,
    input  logic [F_WIDTH-1:0] wdata,
    input  logic [A_WIDTH-1:0] raddr,
    output logic [F_WIDTH-1:0] rdata
);

    logic [F_WIDTH-1:0] mem [F_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO: arbitrary depth, occupancy count, programmable almost flags,
// overflow/underflow pulses and a standard or first-word-fall-through read mode.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int F_WIDTH   = 8,
    parameter int F_DEPTH   = 4,
    parameter int A_WIDTH   = 2,
    parameter int AF_THRESH = F_DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = FIFO_STD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [F_WIDTH-1:0] din,
    input  logic               enq,
    input  logic               deq,
    output logic [F_WIDTH-1:0] dout,
    output logic               valid,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [A_WIDTH:0]   count,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [A_WIDTH:0] DEPTH_C = (A_WIDTH + 1)'(F_DEPTH);
    localparam logic [A_WIDTH:0] AF_C    = (A_WIDTH + 1)'(AF_THRESH);
    localparam logic [A_WIDTH:0] AE_C    = (A_WIDTH + 1)'(AE_THRESH);

    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] rd_ptr;
    logic [F_WIDTH-1:0] rd_data;
    logic               wr_ok;
    logic               rd_ok;

    // Handshake: enq/deq are single-cycle requests judged against the registered state.
    // An accepted request transfers one word at that edge; a rejected one is dropped and
    // reported by a one-cycle overflow/underflow pulse, never held over to a later cycle.
    assign wr_ok = enq & ~full;
    assign rd_ok = deq & ~empty;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    fifo_mem #(
        .F_WIDTH (F_WIDTH),
        .F_DEPTH (F_DEPTH),
        .A_WIDTH (A_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= A_WIDTH'(next_ptr(int'(wr_ptr), F_DEPTH));
            end
            if (rd_ok) begin
                rd_ptr <= A_WIDTH'(next_ptr(int'(rd_ptr), F_DEPTH));
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= enq & full;
            underflow <= deq & empty;
        end
    end

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; no din-to-dout bypass while empty.
            assign dout  = empty ? '0 : rd_data;
            assign valid = ~empty;
        end else begin : g_std
            logic [F_WIDTH-1:0] dout_q;
            logic               valid_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok) begin
                        dout_q <= rd_data;
                    end
                end
            end

            assign dout  = dout_q;
            assign valid = valid_q;
        end
    endgenerate

endmodule
